// File: rtl/iir_pkg.sv
// Shared defaults and sample type for the multi-channel IIR scheduler.
// Optional build macro IIR_SCHED_SAT_EN selects saturating arithmetic in the top.
package iir_pkg;
  localparam int N_DEF        = 16;
  localparam int IIRCONST_DEF = 6;

  typedef logic signed [N_DEF-1:0] sample_t;
endpackage

// File: rtl/iir_channel_scheduler_arb.sv
// Round-robin arbiter: the search starts one past the last granted channel.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last_grant,
  output logic [NCH-1:0] grant
);
  logic          found;
  logic [CW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CW'((int'(last_grant) + i) % NCH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/iir_channel_scheduler.sv
// Multi-channel first-order IIR with one shared update datapath and round-robin input grant.
// Define IIR_SCHED_SAT_EN for a widened difference and saturated sum; default build wraps.
module iir_channel_scheduler
  import iir_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int NCH      = 4,
  parameter int IIRCONST = IIRCONST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*N-1:0]      in_data,
  output logic [NCH-1:0]        in_ready,
  input  logic                  clr_valid,
  input  logic [$clog2(NCH)-1:0] clr_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic signed [N-1:0]   out_data
);
  localparam int CW = $clog2(NCH);

`ifdef IIR_SCHED_SAT_EN
  function automatic logic signed [N-1:0] sat(input logic signed [N+1:0] x);
    logic signed [N+1:0] hi, lo;
    hi = '0;
    hi[N-2:0] = '1;
    lo = '1;
    lo[N-2:0] = '0;
    if (x > hi)      sat = hi[N-1:0];
    else if (x < lo) sat = lo[N-1:0];
    else             sat = x[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] iir_update(input logic signed [N-1:0] st,
                                                      input logic signed [N-1:0] x);
    logic signed [N:0]   d;
    logic signed [N+1:0] s;
    d = {x[N-1], x} - {st[N-1], st};
    d = d >>> IIRCONST;
    s = {{2{st[N-1]}}, st} + {d[N], d};
    iir_update = sat(s);
  endfunction
`else
  function automatic logic signed [N-1:0] iir_update(input logic signed [N-1:0] st,
                                                      input logic signed [N-1:0] x);
    logic signed [N-1:0] d;
    d = x - st;
    d = d >>> IIRCONST;
    iir_update = st + d;
  endfunction
`endif

  logic signed [N-1:0] state_q [NCH];
  logic [CW-1:0]       last_grant;
  logic [NCH-1:0]      clr_mask, req, grant;
  logic [CW-1:0]       gidx_p0;
  logic signed [N-1:0] upd_p0;
  logic                stall, clr_hit, xfer_p0;
  logic                vld_p1;
  logic [CW-1:0]       ch_p1;
  logic signed [N-1:0] data_p1;

  assign stall    = vld_p1 && !out_ready;
  assign clr_hit  = clr_valid && (int'(clr_ch) < NCH);
  assign clr_mask = clr_hit ? (NCH'(1) << clr_ch) : '0;
  // A cleared channel is masked so the clear never races a same-cycle update.
  assign req      = (rst && !stall) ? (in_valid & ~clr_mask) : '0;

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign in_ready = grant;
  assign xfer_p0  = |grant;

  always_comb begin
    gidx_p0 = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) gidx_p0 = CW'(i);
  end

  assign upd_p0 = iir_update(state_q[gidx_p0], in_data[gidx_p0*N +: N]);

  // Stage p0 -> p1: commit state and register the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= '0;
      vld_p1     <= 1'b0;
      ch_p1      <= '0;
      data_p1    <= '0;
      last_grant <= CW'(NCH - 1);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr_mask[i])   state_q[i] <= '0;
        else if (grant[i]) state_q[i] <= upd_p0;
      end
      if (xfer_p0) begin
        vld_p1     <= 1'b1;
        ch_p1      <= gidx_p0;
        data_p1    <= upd_p0;
        last_grant <= gidx_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;
  assign out_data  = data_p1;
endmodule
